// File: rtl/vpe_requant_pack_pkg.sv
// Shared VPU requant definitions: int8 limits, product-width helper and the
// packed-lane type used by the packer and its consumers.
package vpe_requant_pack_pkg;

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;
    localparam int VPE_PACK = 4;

    typedef logic [VPE_PACK-1:0][7:0] lane_vec_t;

    // Signed psum times unsigned scale: one extra bit carries the scale's
    // zero-extended sign so the product never truncates.
    function automatic int prod_width(input int psum_w, input int scale_w);
        return psum_w + scale_w + 1;
    endfunction

endpackage

// File: rtl/vpe_requant_pack_if.sv
// Psum input stream and packed-word output stream of the requant packer.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The source holds data/last/keep stable while valid=1 and
// ready=0; ready may depend combinationally on the sink's state.
interface vpe_requant_pack_if #(
    parameter int PSUM_WIDTH = 32,
    parameter int PACK       = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [PSUM_WIDTH-1:0] in_data;
    logic                  in_last;

    logic                  out_valid;
    logic                  out_ready;
    logic [8*PACK-1:0]     out_data;
    logic [PACK-1:0]       out_keep;
    logic                  out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/vpe_requant_core.sv
// Two-stage requant arithmetic: S1 multiplies by the scale, S2 rounds,
// shifts, adds the zero point and saturates to int8. Both stages freeze on hold.
module vpe_requant_core
    import vpe_requant_pack_pkg::*;
#(
    parameter int PSUM_WIDTH  = 32,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   in_fire,
    input  logic [PSUM_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    input  logic [SCALE_WIDTH-1:0] scale,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [7:0]             zero_point,
    output logic                   s1_valid,
    output logic                   s2_valid,
    output logic [7:0]             s2_byte,
    output logic                   s2_last
);

    localparam int PW = prod_width(PSUM_WIDTH, SCALE_WIDTH);
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] Z_MAX = RW'(INT8_MAX);
    localparam logic signed [RW-1:0] Z_MIN = RW'(INT8_MIN);

    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] scale_ext;
    logic signed [PW-1:0] prod_next;
    logic signed [PW-1:0] s1_prod;
    logic                 s1_last;

    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] rsum;
    logic signed [RW-1:0] shifted;
    logic signed [RW-1:0] zsum;
    logic [7:0]           byte_next;

    always_comb begin
        data_ext  = {{(PW-PSUM_WIDTH){in_data[PSUM_WIDTH-1]}}, in_data};
        scale_ext = {{(PW-SCALE_WIDTH){1'b0}}, scale};
        prod_next = data_ext * scale_ext;
    end

    // One extra bit above the product absorbs the rounding addend, so the
    // saturation compare always sees the exact value.
    always_comb begin
        rnd = '0;
        if (shift != '0) begin
            rnd = RW'(1) << (shift - SHIFT_WIDTH'(1));
        end
        rsum    = {s1_prod[PW-1], s1_prod} + rnd;
        shifted = rsum >>> shift;
        zsum    = shifted + {{(RW-8){zero_point[7]}}, zero_point};
        byte_next = zsum[7:0];
        if (zsum > Z_MAX) begin
            byte_next = 8'(INT8_MAX);
        end else if (zsum < Z_MIN) begin
            byte_next = 8'(INT8_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_prod  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_byte  <= '0;
        end else if (!hold) begin
            s1_valid <= in_fire;
            s1_last  <= in_last;
            s1_prod  <= prod_next;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_byte  <= byte_next;
        end
    end

endmodule

// File: rtl/vpe_requant_pack.sv
// Requantize 32-bit psums to int8 and pack PACK lanes per output word, with
// last/keep flushing of partial words and full backpressure.
module vpe_requant_pack
    import vpe_requant_pack_pkg::*;
#(
    parameter int PSUM_WIDTH  = 32,
    parameter int SCALE_WIDTH = 16,
    parameter int SHIFT_WIDTH = 6,
    parameter int PACK        = VPE_PACK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SCALE_WIDTH-1:0] rq_scale,
    input  logic [SHIFT_WIDTH-1:0] rq_shift,
    input  logic [7:0]             rq_zero_point,
    vpe_requant_pack_if.slave      stream,
    output logic                   busy
);

    localparam int CW = (PACK > 1) ? $clog2(PACK) : 1;

    logic                   stall;
    logic                   in_fire;
    logic                   s1_valid;
    logic                   s2_valid;
    logic [7:0]             s2_byte;
    logic                   s2_last;

    logic [CW-1:0]          cnt_q;
    logic [PACK-1:0][7:0]   lanes_q;
    logic [PACK-1:0][7:0]   lanes_next;
    logic [PACK-1:0]        keep_next;
    logic                   word_done;

    logic                   out_valid_q;
    logic [PACK-1:0][7:0]   out_data_q;
    logic [PACK-1:0]        out_keep_q;
    logic                   out_last_q;

    // A word that cannot leave freezes the whole pipe, input side included.
    assign stall           = out_valid_q & ~stream.out_ready;
    assign stream.in_ready = ~stall;
    assign in_fire         = stream.in_valid & ~stall;

    vpe_requant_core #(
        .PSUM_WIDTH  (PSUM_WIDTH),
        .SCALE_WIDTH (SCALE_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .in_fire    (in_fire),
        .in_data    (stream.in_data),
        .in_last    (stream.in_last),
        .scale      (rq_scale),
        .shift      (rq_shift),
        .zero_point (rq_zero_point),
        .s1_valid   (s1_valid),
        .s2_valid   (s2_valid),
        .s2_byte    (s2_byte),
        .s2_last    (s2_last)
    );

    always_comb begin
        lanes_next        = lanes_q;
        lanes_next[cnt_q] = s2_byte;
        word_done         = s2_valid & ((cnt_q == CW'(PACK - 1)) | s2_last);
        keep_next         = '0;
        for (int i = 0; i < PACK; i++) begin
            keep_next[i] = (CW'(i) <= cnt_q);
        end
    end

    // Lanes are cleared whenever a word leaves the packer, so unused lanes of
    // a flushed partial word are already zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            lanes_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (!stall) begin
            if (word_done) begin
                cnt_q       <= '0;
                lanes_q     <= '0;
                out_valid_q <= 1'b1;
                out_data_q  <= lanes_next;
                out_keep_q  <= keep_next;
                out_last_q  <= s2_last;
            end else begin
                if (s2_valid) begin
                    cnt_q   <= cnt_q + CW'(1);
                    lanes_q <= lanes_next;
                end
                if (out_valid_q && stream.out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_keep  = out_keep_q;
    assign stream.out_last  = out_last_q;

    assign busy = s1_valid | s2_valid | (cnt_q != '0) | out_valid_q;

endmodule

// File: tb/tb_vpe_requant_pack.sv
// Scoreboarded bench for vpe_requant_pack: a plain-arithmetic reference model
// predicts packed words at issue time; a negedge monitor checks every handshake.
module tb_vpe_requant_pack;
    import vpe_requant_pack_pkg::*;

    localparam int PW   = 32;
    localparam int PACK = 4;
    localparam int EW   = 8 * PACK + PACK + 1;

    logic        clk;
    logic        rst;
    logic [15:0] rq_scale;
    logic [5:0]  rq_shift;
    logic [7:0]  rq_zero_point;
    logic        busy;

    vpe_requant_pack_if #(.PSUM_WIDTH(PW), .PACK(PACK)) bus ();

    vpe_requant_pack #(
        .PSUM_WIDTH  (PW),
        .SCALE_WIDTH (16),
        .SHIFT_WIDTH (6),
        .PACK        (PACK)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rq_scale      (rq_scale),
        .rq_shift      (rq_shift),
        .rq_zero_point (rq_zero_point),
        .stream        (bus),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    logic [7:0]    cur_q[$];

    int            words_seen = 0;
    logic [31:0]   last_word  = '0;
    logic [3:0]    last_keep  = '0;
    logic          last_last  = 1'b0;

    int ready_mode = 0;
    int ready_lo   = 0;
    int ready_hi   = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_byte(input int psum);
        longint v;
        logic [63:0] bits;
        v = longint'(psum) * longint'(rq_scale);
        if (rq_shift > 0) v = v + (longint'(1) << (int'(rq_shift) - 1));
        v = v >>> int'(rq_shift);
        v = v + longint'($signed(rq_zero_point));
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        bits = v;
        return bits[7:0];
    endfunction

    task automatic model_push(input int psum, input bit last);
        logic [31:0] word;
        logic [3:0]  keep;
        cur_q.push_back(ref_byte(psum));
        if (cur_q.size() == PACK || last) begin
            word = '0;
            keep = '0;
            foreach (cur_q[i]) begin
                word[8*i +: 8] = cur_q[i];
                keep[i] = 1'b1;
            end
            exp_q.push_back({last, keep, word});
            cur_q.delete();
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0) bus.out_ready = 1'b1;
            else if (ready_mode == 1) bus.out_ready = !(cyc >= ready_lo && cyc < ready_hi);
            else bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input int d, input bit l);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("accept_timeout", 64'(bus.in_ready), 64'(1));
        end else begin
            @(posedge clk);
            model_push(d, l);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("idle_timeout", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic set_cfg(input int scale, input int shift, input int zp);
        wait_idle();
        rq_scale      = 16'(scale);
        rq_shift      = 6'(shift);
        rq_zero_point = 8'(zp);
    endtask

    function automatic int rand_psum();
        case ($urandom_range(0, 3))
            0: return int'($urandom());
            1: return int'($urandom_range(0, 1000));
            2: return -int'($urandom_range(0, 500));
            default: return int'($urandom_range(100000, 2000000000));
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] got;
        logic [EW-1:0] want;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("in_ready_vs_stall", 64'(bus.in_ready),
                      64'(!(bus.out_valid && !bus.out_ready)));
                if (bus.out_valid && bus.out_ready) begin
                    got = {bus.out_last, bus.out_keep, bus.out_data};
                    words_seen++;
                    last_word = bus.out_data;
                    last_keep = bus.out_keep;
                    last_last = bus.out_last;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 64'(got), 64'(0));
                    end else begin
                        want = exp_q.pop_front();
                        check("word", 64'(got), 64'(want));
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int ws0;
        int n;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        rq_scale      = 16'd1;
        rq_shift      = 6'd0;
        rq_zero_point = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data",  64'(bus.out_data),  64'(0));
        check("rst_out_keep",  64'(bus.out_keep),  64'(0));
        check("rst_out_last",  64'(bus.out_last),  64'(0));
        check("rst_busy",      64'(busy),          64'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

        // identity with latency
        set_cfg(1, 0, 0);
        send(1, 0); send(2, 0); send(3, 0); send(4, 0);
        check("lat_after_e0", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("lat_after_e1", 64'(bus.out_valid), 64'(0));
        @(negedge clk);
        check("lat_after_e2", 64'(bus.out_valid), 64'(1));
        check("identity_data", 64'(bus.out_data), 64'h04030201);
        check("identity_keep", 64'(bus.out_keep), 64'hF);
        check("identity_last", 64'(bus.out_last), 64'(0));
        wait_idle();

        // saturation
        send(300, 0); send(-300, 0); send(127, 0); send(-128, 0);
        wait_idle();
        check("sat_word", 64'(last_word), 64'h807F807F);

        // rounding, with config changed only while idle
        set_cfg(3, 2, 0);
        send(5, 0); send(-5, 1);
        wait_idle();
        check("round_word", 64'(last_word), 64'h0000FC04);
        set_cfg(1, 2, 0);
        send(2, 0); send(-2, 1);
        wait_idle();
        check("round_half_word", 64'(last_word), 64'h00000001);
        check("round_half_keep", 64'(last_keep), 64'h3);
        set_cfg(3, 2, 10);
        send(5, 1);
        wait_idle();
        check("zp_word", 64'(last_word), 64'h0000000E);
        check("zp_keep", 64'(last_keep), 64'h1);

        // partial flush, then next tile restarts at lane 0
        set_cfg(1, 0, 0);
        send(1, 0); send(2, 1);
        wait_idle();
        check("flush_word", 64'(last_word), 64'h00000201);
        check("flush_keep", 64'(last_keep), 64'h3);
        check("flush_last", 64'(last_last), 64'(1));
        send(5, 0); send(6, 0); send(7, 0); send(8, 0);
        wait_idle();
        check("after_flush_word", 64'(last_word), 64'h08070605);
        check("after_flush_keep", 64'(last_keep), 64'hF);

        // backpressure: 5-cycle out_ready hole mid-stream
        ws0 = words_seen;
        ready_lo   = cyc + 6;
        ready_hi   = cyc + 11;
        ready_mode = 1;
        for (int i = 0; i < 16; i++) send(int'($urandom_range(0, 400)) - 200, 0);
        wait_idle();
        ready_mode = 0;
        check("bp_word_count", 64'(words_seen - ws0), 64'(4));

        // reset mid-stream with two lanes packed and S1/S2 occupied
        set_cfg(1, 0, 0);
        send(11, 0); send(12, 0); send(13, 0); send(14, 0);
        rst = 1'b0;
        exp_q.delete();
        cur_q.delete();
        @(negedge clk);
        rst = 1'b1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_busy",      64'(busy),          64'(0));
        ws0 = words_seen;
        send(9, 0); send(8, 0); send(7, 0); send(6, 0);
        wait_idle();
        check("midrst_word",  64'(last_word), 64'h06070809);
        check("midrst_count", 64'(words_seen - ws0), 64'(1));

        // randomized tiles with random backpressure and input gaps
        for (int t = 0; t < 14; t++) begin
            ready_mode = 0;
            set_cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 47)),
                    int'($urandom_range(0, 255)));
            ready_mode = 2;
            n = int'($urandom_range(1, 20));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                send(rand_psum(), (k == n - 1) || ($urandom_range(0, 9) == 0));
            end
        end
        wait_idle();
        ready_mode = 0;
        @(negedge clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        check("final_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpe_requant_pack.md
Name: vpe_requant_pack

Overview:
Downstream neighbour of the VPU ReLU stage. It takes 32-bit post-activation psums (one per cycle, valid/ready) and requantizes each to int8 (scale multiply, round-half-up right shift, zero-point add, saturate). It packs PACK consecutive int8 results into one output word for the writeback path, with backpressure and a last/keep mechanism for partial words.

Parameters:
PSUM_WIDTH, 32, input psum width (signed)
SCALE_WIDTH, 16, unsigned requant multiplier width
SHIFT_WIDTH, 6, right-shift amount width (legal shift 0..47)
PACK, 4, int8 lanes per output word

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets on rising clk)
rq_scale  in  SCALE_WIDTH  unsigned multiplier; quasi-static
rq_shift  in  SHIFT_WIDTH  right shift; quasi-static
rq_zero_point  in  8  signed int8 zero point; quasi-static
in_valid  in  1  psum valid
in_ready  out  1  block can accept psum this cycle
in_data  in  PSUM_WIDTH  signed psum (ReLU output)
in_last  in  1  final element of tile; flush partial word
out_valid  out  1  packed word valid
out_ready  in  1  consumer accepts word
out_data  out  8*PACK  packed int8 lanes, lane i at bits [8i+7:8i]
out_keep  out  PACK  per-lane valid mask
out_last  out  1  word contains the tile's last element
busy  out  1  any pipeline stage, packer or output register holds data

Behaviour:
- Reset (rst=0 at clk edge): all valid bits 0, lane counter 0, out_data=0, out_keep=0, out_last=0, out_valid=0, busy=0. in_ready=1 in the cycle after reset releases. Reset mid-operation discards all in-flight data with no partial output.
- stall = out_valid & ~out_ready. in_ready = ~stall (combinational). While stalled, S1, S2, packer and output register all hold.
- Accept on in_valid & in_ready.
- S1, registered: prod = signed(in_data) * unsigned(rq_scale). Full width PSUM_WIDTH+SCALE_WIDTH+1 signed, no truncation. Carries last.
- S2, registered: r = prod + (rq_shift>0 ? 1<<(rq_shift-1) : 0); q = r >>> rq_shift (arithmetic); z = q + sext(rq_zero_point); byte = clamp(z, -128, 127). Saturation is evaluated on the full-width z. Carries last.
- Packer, on a non-stalled edge with S2 valid: the byte is written to lane cnt.
  - If cnt==PACK-1 or last: load the output register (out_data = collected lanes with unused lanes 0; out_keep = lanes 0..cnt set; out_last = last; out_valid = 1) and set cnt=0.
  - Otherwise cnt++.
- Output register: cleared to out_valid=0 on out_valid&out_ready, unless a new word completes on the same edge, in which case the new word loads and out_valid stays 1 (back-to-back full rate).
- Latency: psum accepted at edge E0 reaches S2 at E1 and the packer at E2. A completing word is visible (out_valid=1) after E2, i.e. 3 cycles from accept. Throughput is 1 psum/cycle absent backpressure.
- S2 bubbles (no valid) leave the packer unchanged; a partial word waits indefinitely for more data or last.
- in_last with cnt==0 emits a 1-lane word (keep=0x1).
- rq_scale/shift/zero_point may change only when busy=0. Otherwise results are undefined. rq_shift>47 is illegal.

Decomposition:
- Shared VPU package: INT8_MIN/INT8_MAX constants, a product-width localparam function, and a packed-lane typedef (logic [PACK-1:0][7:0]).
- One natural sub-module: vpe_requant_core (S1/S2 arithmetic pipeline with valid/last and hold enable). The packer and output register stay in the top.

Test Plan:
- Identity: scale=1, shift=0, zp=0; psums 1,2,3,4 back-to-back -> one word out_data=0x04030201, keep=0xF, last=0, 3 cycles after 4th accept.
- Saturation: scale=1, shift=0, zp=0; psums 300, -300, 127, -128 -> 0x807F807F (lanes 0x7F,0x80,0x7F,0x80).
- Rounding: scale=3, shift=2; psums 5, -5, 2 (scale=1), -2 (scale=1, changed while idle, new tile) -> 4, -4 (0xFC), 1, 0. zp=10 added to psum 5 -> 14.
- Partial flush: psums 1, 2 with last on 2nd -> out_data=0x00000201, keep=0x3, out_last=1. Next tile starts in lane 0.
- Backpressure: stream 16 psums with out_ready toggled 0 for 5 cycles mid-stream -> in_ready=0 exactly while stalled, 4 words delivered in order, none lost or duplicated; full-rate back-to-back words when out_ready=1.
- Reset mid-stream: assert rst=0 with 2 lanes packed and S1/S2 valid -> out_valid=0, busy=0 next cycle; subsequent psums 9,8,7,6 -> 0x06070809.
